aes_core: RTL and testbench
===========================

# aes_core

Iterative AES-128 decryption core: takes a 128-bit ciphertext block and the final (round-10) AES-128 round key, and produces the plaintext after ten inverse rounds. It runs the key schedule in reverse, one round per clock. It free-runs, re-sampling its inputs for a new block immediately after each completion. It sits as a leaf datapath block with no host handshake beyond the `finished` strobe.

## Interface
- No parameters. Key size is fixed at 128 bits and Nr = 10.
- `clk` input 1: single clock; everything is rising-edge.
- `rst_n` input 1: one clock; reset is synchronous and active-high. 1 = reset, sampled on the `clk` rising edge.
- `data_in` input 128: ciphertext block. Bits [127:120] are byte 0, in FIPS-197 column-major order.
- `key` input 128: round-10 key (last AES-128 round key), same byte order.
- `data_out` output 128: plaintext of the last completed block; registered.
- `finished` output 1: high for exactly one cycle when `data_out` has just been updated.

## Operation
- FSM states:
  - **LOAD**: state ← `data_in` ^ `key`; rk ← `key`; round ← 10; next state ROUND.
  - **ROUND**:
    - rk_prev = InvKeyExp(rk, Rcon[round]).
    - state ← InvShiftRows → InvSubBytes → AddRoundKey(rk_prev) → InvMixColumns.
    - InvMixColumns is omitted when round == 1.
    - rk ← rk_prev; round ← round−1.
    - When round == 1, also load `data_out` ← result, set `finished` ← 1, and go to DONE.
  - **DONE**: `finished` ← 0; next state LOAD.
- InvKeyExp on words w0..w3 (w0 = bits [127:96]):
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r],24'h0}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- SubWord uses the forward S-box. The data path uses the inverse S-box. InvMixColumns uses the GF(2^8) multipliers 0e,0b,0d,09 with polynomial 0x11b.
- `data_in` and `key` are sampled only in LOAD. Changes during ROUND/DONE affect only the next block.
- `data_out` holds its value between completions.
- Reset values: `data_out` = 0, `finished` = 0, FSM = LOAD, round = 0, internal state and rk = 0.

## Timing
- Let edge E0 be the first rising edge with `rst_n` = 0 after reset. LOAD executes at E0, and rounds 10..1 execute at E1..E10.
- `data_out` and `finished` update at E10. `finished` is high during the cycle after E10 and low again after E11.
- Next LOAD occurs at E12. Block period is 12 cycles; latency from input sampling to valid output is 11 cycles.
- Reset asserted at any edge wins over all other activity. Outputs clear at that edge, any in-flight block is discarded, and the full sequence restarts from LOAD on the first edge with reset deasserted.
- If reset is asserted in the same edge where `finished` would rise, `finished` stays 0 and `data_out` becomes 0.
- There is no back-pressure. Consumers must capture `data_out` any time before the next `finished` pulse.

## Test plan
- FIPS-197 App. B: `data_in`=3925841d02dc09fbdc118597196a0b32, `key`=d014f9a8c9ee2589e13f0cc8b6630ca6. Required: `data_out`=3243f6a8885a308d313198a2e0370734 with `finished` high, 11 cycles after the sampling LOAD.
- FIPS-197 App. C.1: `data_in`=69c4e0d86a7b0430d8cdb78070b4c55a, `key`=13111d7fe3944a17f307a78b4d2b30c5. Required: `data_out`=00112233445566778899aabbccddeeff.
- Input change mid-block: apply the App. B vector, then switch to the C.1 vector 3 cycles after LOAD. Required: first pulse gives 3243f6a8…0734; the next pulse, 12 cycles later, gives 00112233…eeff.
- Pulse shape under constant inputs: `finished` is high exactly 1 cycle of every 12, and `data_out` is unchanged between pulses.
- Reset mid-operation: assert reset 5 cycles after LOAD. Required: `data_out`=0 and `finished`=0 on the next edge; after release, the first pulse arrives exactly 11 cycles after the new LOAD, with the correct value.
- Reset held many cycles: outputs stay 0 and `finished` never pulses.

Source files
------------

// File: rtl/aes_core.sv
// aes_core: iterative AES-128 decryption, one inverse round per clock.
// Free-running: LOAD samples data_in/key, ten ROUND cycles follow, then DONE,
// then the next LOAD. The key schedule is walked backwards from the round-10 key.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - synchronous reset, active HIGH (1 = reset)
//   data_in  - 128-bit ciphertext, byte 0 in bits [127:120]
//   key      - 128-bit round-10 key, same byte order
//   data_out - registered plaintext of the last completed block
//   finished - one-cycle strobe, high the cycle after data_out updates
module aes_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] data_in,
   input  logic [127:0] key,
   output logic [127:0] data_out,
   output logic         finished
);

   typedef enum logic [1:0] {StLoad, StRound, StDone} state_e;

   state_e       st_q, st_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rk_q, rk_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] data_out_d;
   logic         finished_d;

   // GF(2^8) multiply, polynomial 0x11b.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] t;
      t = {x, x} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] i;
      i = gf_inv(x);
      return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      logic [7:0] y;
      y = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
      return gf_inv(y);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      unique case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Previous round key from the current one.
   logic [31:0]  w0, w1, w2, w3, w0n, w1n, w2n, w3n, rot_w, sub_w;
   logic [127:0] rk_prev;

   always_comb begin
      w0    = rk_q[127:96];
      w1    = rk_q[95:64];
      w2    = rk_q[63:32];
      w3    = rk_q[31:0];
      w3n   = w3 ^ w2;
      w2n   = w2 ^ w1;
      w1n   = w1 ^ w0;
      rot_w = {w3n[23:0], w3n[31:24]};
      sub_w = {sbox_fwd(rot_w[31:24]), sbox_fwd(rot_w[23:16]),
               sbox_fwd(rot_w[15:8]), sbox_fwd(rot_w[7:0])};
      w0n   = w0 ^ sub_w ^ {rcon(round_q), 24'h0};
      rk_prev = {w0n, w1n, w2n, w3n};
   end

   // One inverse round on state_q.
   logic [127:0] isr, isb, ark, imc, round_out;
   logic [7:0]   s0, s1, s2, s3;

   always_comb begin
      isr = '0;
      imc = '0;
      s0  = 8'h00;
      s1  = 8'h00;
      s2  = 8'h00;
      s3  = 8'h00;
      // Row r rotates right by r: out[r][c] = in[r][c - r].
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            isr[127 - 8 * (4 * c + r) -: 8] = state_q[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
         end
      end
      for (int b = 0; b < 16; b++) begin
         isb[127 - 8 * b -: 8] = sbox_inv(isr[127 - 8 * b -: 8]);
      end
      ark = isb ^ rk_prev;
      for (int c = 0; c < 4; c++) begin
         s0 = ark[127 - 32 * c -: 8];
         s1 = ark[119 - 32 * c -: 8];
         s2 = ark[111 - 32 * c -: 8];
         s3 = ark[103 - 32 * c -: 8];
         imc[127 - 32 * c -: 8] = gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^
                                  gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09);
         imc[119 - 32 * c -: 8] = gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^
                                  gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d);
         imc[111 - 32 * c -: 8] = gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^
                                  gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b);
         imc[103 - 32 * c -: 8] = gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^
                                  gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e);
      end
      // Last round has no InvMixColumns.
      round_out = (round_q == 4'd1) ? ark : imc;
   end

   always_comb begin
      st_d       = st_q;
      state_d    = state_q;
      rk_d       = rk_q;
      round_d    = round_q;
      data_out_d = data_out;
      finished_d = 1'b0;
      unique case (st_q)
         StLoad: begin
            state_d = data_in ^ key;
            rk_d    = key;
            round_d = 4'd10;
            st_d    = StRound;
         end
         StRound: begin
            state_d = round_out;
            rk_d    = rk_prev;
            round_d = round_q - 4'd1;
            if (round_q == 4'd1) begin
               data_out_d = round_out;
               finished_d = 1'b1;
               st_d       = StDone;
            end
         end
         StDone: st_d = StLoad;
         default: st_d = StLoad;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         st_q     <= StLoad;
         state_q  <= '0;
         rk_q     <= '0;
         round_q  <= 4'd0;
         data_out <= '0;
         finished <= 1'b0;
      end else begin
         st_q     <= st_d;
         state_q  <= state_d;
         rk_q     <= rk_d;
         round_q  <= round_d;
         data_out <= data_out_d;
         finished <= finished_d;
      end
   end

endmodule

// File: tb/tb_aes_core.sv
module tb_aes_core;

   logic         clk;
   logic         rst_n;
   logic [127:0] data_in;
   logic [127:0] key;
   logic [127:0] data_out;
   logic         finished;

   aes_core dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .key      (key),
      .data_out (data_out),
      .finished (finished)
   );

   localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference tables built by brute force: inverse by search, then affine map.
   logic [7:0] sb_t [256];
   logic [7:0] isb_t[256];

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 0; x = a; y = b;
      while (y != 0) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   initial begin
      logic [7:0] v, b, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         v = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
         for (int i = 0; i < 8; i++)
            b[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
         sb_t[x]  = b;
         isb_t[b] = 8'(x);
      end
   end

   // Textbook decryption: expand all round keys backwards, then 10 inverse rounds.
   function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] k);
      logic [31:0]  w[44];
      logic [7:0]   rc[11];
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [31:0]  tmp;
      logic [127:0] res;
      rc[0] = 8'h00;
      rc[1] = 8'h01;
      for (int i = 2; i <= 10; i++) rc[i] = gm(rc[i - 1], 8'h02);
      for (int j = 0; j < 4; j++) w[40 + j] = k[127 - 32 * j -: 32];
      for (int i = 43; i >= 4; i--) begin
         tmp = w[i - 1];
         if (i % 4 == 0)
            tmp = {sb_t[tmp[23:16]], sb_t[tmp[15:8]], sb_t[tmp[7:0]], sb_t[tmp[31:24]]}
                  ^ {rc[i / 4], 24'h0};
         w[i - 4] = w[i] ^ tmp;
      end
      for (int b = 0; b < 16; b++) begin
         tmp  = w[40 + b / 4];
         s[b] = ct[127 - 8 * b -: 8] ^ tmp[31 - 8 * (b % 4) -: 8];
      end
      for (int r = 9; r >= 0; r--) begin
         for (int cc = 0; cc < 4; cc++)
            for (int rr = 0; rr < 4; rr++) t[4 * cc + rr] = s[4 * ((cc - rr + 4) % 4) + rr];
         for (int b = 0; b < 16; b++) begin
            tmp  = w[4 * r + b / 4];
            s[b] = isb_t[t[b]] ^ tmp[31 - 8 * (b % 4) -: 8];
         end
         if (r > 0) begin
            for (int cc = 0; cc < 4; cc++) begin
               for (int rr = 0; rr < 4; rr++) t[rr] = s[4 * cc + rr];
               s[4 * cc + 0] = gm(t[0], 8'h0e) ^ gm(t[1], 8'h0b) ^ gm(t[2], 8'h0d) ^ gm(t[3], 8'h09);
               s[4 * cc + 1] = gm(t[0], 8'h09) ^ gm(t[1], 8'h0e) ^ gm(t[2], 8'h0b) ^ gm(t[3], 8'h0d);
               s[4 * cc + 2] = gm(t[0], 8'h0d) ^ gm(t[1], 8'h09) ^ gm(t[2], 8'h0e) ^ gm(t[3], 8'h0b);
               s[4 * cc + 3] = gm(t[0], 8'h0b) ^ gm(t[1], 8'h0d) ^ gm(t[2], 8'h09) ^ gm(t[3], 8'h0e);
            end
         end
      end
      for (int b = 0; b < 16; b++) res[127 - 8 * b -: 8] = s[b];
      return res;
   endfunction

   // Schedule model: 12-cycle frame after reset, sample at phase 0, publish at phase 10.
   int           m_ph;
   logic [127:0] m_pend, m_out;
   logic         m_fin;

   always @(posedge clk) begin
      if (rst_n) begin
         m_ph   <= 0;
         m_pend <= '0;
         m_out  <= '0;
         m_fin  <= 1'b0;
      end else begin
         if (m_ph == 0) m_pend <= aes_dec(data_in, key);
         m_fin <= (m_ph == 10);
         if (m_ph == 10) m_out <= m_pend;
         m_ph <= (m_ph == 11) ? 0 : m_ph + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (finished !== m_fin || data_out !== m_out) begin
            errors++;
            $display("FAIL model_cycle t=%0t finished=%b want %b data_out=%h want %h",
                     $time, finished, m_fin, data_out, m_out);
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_pulse(input string name, input int exp_n, input logic [127:0] exp_d);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!finished && n < 40);
      chk({name, "_latency"}, 128'(n), 128'(exp_n));
      chk({name, "_data"}, data_out, exp_d);
   endtask

   initial begin
      rst_n   = 1'b1;
      data_in = CT_B;
      key     = K_B;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // Pin the reference model itself.
      chk("model_sbox_00", 128'(sb_t[8'h00]), 128'h63);
      chk("model_sbox_53", 128'(sb_t[8'h53]), 128'hed);
      chk("model_isbox_16", 128'(isb_t[8'h16]), 128'hff);
      chk("model_dec_b", aes_dec(CT_B, K_B), PT_B);
      chk("model_dec_c", aes_dec(CT_C, K_C), PT_C);

      // Long reset: nothing moves.
      step(20);
      chk("reset_hold_data", data_out, '0);
      chk("reset_hold_fin", 128'(finished), 128'h0);

      // App. B.
      rst_n = 1'b0;
      wait_pulse("app_b", 11, PT_B);

      // Switch to C.1 three cycles after the next LOAD.
      step(5);
      data_in = CT_C;
      key     = K_C;
      wait_pulse("midchg_first", 7, PT_B);
      wait_pulse("midchg_second", 12, PT_C);
      wait_pulse("steady_1", 12, PT_C);
      wait_pulse("steady_2", 12, PT_C);

      // Reset five cycles after LOAD.
      step(6);
      rst_n = 1'b1;
      step(1);
      chk("rst_mid_data", data_out, '0);
      chk("rst_mid_fin", 128'(finished), 128'h0);
      step(2);
      rst_n = 1'b0;
      wait_pulse("rst_recover", 11, PT_C);

      // Reset on the edge where finished would rise.
      rst_n = 1'b1;
      step(1);
      data_in = CT_B;
      key     = K_B;
      rst_n   = 1'b0;
      step(10);
      rst_n = 1'b1;
      step(1);
      chk("rst_at_done_data", data_out, '0);
      chk("rst_at_done_fin", 128'(finished), 128'h0);
      rst_n = 1'b0;
      wait_pulse("rst_at_done_recover", 11, PT_B);

      step(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
